dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Target side of the dcache_* request interface driven by the memory stage.
- Direct-mapped, write-through, no-write-allocate data cache of 64-bit words.
- Misses and all writes go to a simple request/grant backing-memory bus.
- Sits between the memory stage and the memory/bus arbiter.

Parameters:
SETS, 64, number of lines; power of two, at least 2.
LINE_WORDS, 8, 64-bit words per line; power of two, at least 2.

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous active-low reset
dcache_en  in  1  one-cycle request pulse
dcache_wren  in  1  1 = write, 0 = read; valid with dcache_en
dcache_addr  in  64  byte address; bits [2:0] are ignored
dcache_wdata  in  64  write data; valid with dcache_en
dcache_rdata  out  64  response data; valid while dcache_done is high, then held
dcache_done  out  1  one-cycle completion pulse
mem_req  out  1  backing request; held high until mem_gnt
mem_we  out  1  1 = single-word write, 0 = line read
mem_addr  out  64  word address for writes; line-aligned address for reads
mem_wdata  out  64  write data
mem_gnt  in  1  accepts mem_req; for writes it also marks completion
mem_rvalid  in  1  read beat valid
mem_rdata  in  64  read beat data

Behaviour:
- Reset values:
  - Outputs: dcache_done=0, dcache_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal: all valid bits cleared, state IDLE.
- Reset mid-operation:
  - Any request in flight is abandoned and mem_req drops in the next cycle.
  - The backing bus must discard an abandoned transaction.
- Address split:
  - OFF = 3 + log2(LINE_WORDS), with word index = addr[OFF-1:3].
  - index = addr[OFF+log2(SETS)-1:OFF].
  - tag = addr[63:OFF+log2(SETS)].
- Per-line storage: valid bit, tag, LINE_WORDS data words.
- Request capture:
  - In IDLE, a clk edge with dcache_en=1 latches wren, addr and wdata, then moves to LOOKUP.
  - dcache_en outside IDLE is ignored; the memory stage never issues while waiting.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit: go to RESP with rdata = stored word.
  - Read miss: go to REFILL_REQ.
  - Write, hit or miss: if hit, update the stored word; then go to WRITE_REQ.
- REFILL_REQ:
  - Drive mem_req=1, mem_we=0, mem_addr = line-aligned address.
  - On mem_gnt, clear the beat counter and go to REFILL.
- REFILL:
  - Each mem_rvalid writes mem_rdata into word[counter] and increments the counter.
  - Beats arrive in ascending word order from the line base.
  - Capture the beat whose counter equals the requested word index.
  - After beat LINE_WORDS-1: set valid and tag, then go to RESP.
  - The line is never marked valid before the final beat.
- WRITE_REQ:
  - Drive mem_req=1, mem_we=1, mem_addr = addr with [2:0] cleared, mem_wdata = wdata.
  - On mem_gnt, go to RESP.
  - A write miss does not allocate.
- RESP:
  - dcache_done=1 for exactly one cycle; dcache_rdata = read word, or wdata for writes.
  - Return to IDLE.
  - A new dcache_en is accepted on the edge that leaves RESP, i.e. the cycle after done.
- Latency, counted from the capturing edge:
  - Read hit: done is high in the cycle after LOOKUP, i.e. 2 cycles.
  - Miss: done follows the final mem_rvalid beat by 1 cycle.
  - Write: done follows mem_gnt by 1 cycle.
- mem_req is deasserted in the cycle after mem_gnt. mem_gnt in the same cycle mem_req rises is legal.
- Eviction:
  - A refill overwrites the indexed line unconditionally.
  - Write-through means no dirty state and no writeback.
- mem_rvalid outside REFILL and mem_gnt without mem_req are ignored.
- dcache_rdata only changes in the RESP cycle.

Test Plan:
- Read miss then hit:
  - Read 0x1008. Expect mem_req with mem_addr=0x1000 and mem_we=0.
  - Supply beats 0x10..0x17. Expect done one cycle after the last beat with rdata=0x11.
  - Read 0x1038. Expect done 2 cycles later with rdata=0x17 and no mem_req.
- Write hit: after the fill above, write 0xDEAD to 0x1010.
  - Expect mem_we=1, mem_addr=0x1010, mem_wdata=0xDEAD, and done after mem_gnt.
  - Then read 0x1010. Expect a hit with rdata=0xDEAD.
- Write miss, no allocate: write 0xBEEF to 0x9000.
  - Expect a single write transaction.
  - A following read of 0x9000 misses and issues a refill.
- Conflict eviction (SETS=64, LINE_WORDS=8): fill 0x1000, then read 0x2000 (same index).
  - Expect a refill of the 0x2000 line.
  - Re-reading 0x1000 misses again.
- Busy ignore: pulse dcache_en with read 0x3000 during a refill.
  - Expect no extra mem_req and exactly one done, for the original request.
- Reset mid-refill: assert rst_n=0 after 3 of 8 beats.
  - Expect mem_req=0, done=0 and rdata=0 the next cycle.
  - A read of the same line misses.

Source files
------------

// File: rtl/dcache_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_responder : direct-mapped, write-through, no-write-allocate D-cache
// Revision 1.0
// ---------------------------------------------------------------------------
module dcache_responder #(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dcache_en,
   input  logic        dcache_wren,
   input  logic [63:0] dcache_addr,
   input  logic [63:0] dcache_wdata,
   output logic [63:0] dcache_rdata,
   output logic        dcache_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata
);

   localparam int WORD_BITS = $clog2(LINE_WORDS);
   localparam int IDX_BITS  = $clog2(SETS);
   localparam int OFF       = 3 + WORD_BITS;
   localparam int TAG_BITS  = 64 - OFF - IDX_BITS;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOOKUP     = 3'd1,
      REFILL_REQ = 3'd2,
      REFILL     = 3'd3,
      WRITE_REQ  = 3'd4,
      RESP       = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic                   wren_q, wren_d;
   logic [63:3]            addr_q, addr_d;
   logic [63:0]            wdata_q, wdata_d;
   logic [WORD_BITS-1:0]   cnt_q, cnt_d;
   logic [63:0]            rword_q, rword_d;
   logic [63:0]            rdata_q, rdata_d;
   logic                   done_q, done_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [63:0]            mem_addr_q, mem_addr_d;
   logic [63:0]            mem_wdata_q, mem_wdata_d;
   logic [SETS-1:0]        valid_q, valid_d;

   logic [63:0]            data_mem [SETS*LINE_WORDS];
   logic [TAG_BITS-1:0]    tag_mem  [SETS];

   logic                            arr_we;
   logic [IDX_BITS+WORD_BITS-1:0]   arr_addr;
   logic [63:0]                     arr_wdata;
   logic                            tag_we;

   logic [WORD_BITS-1:0]   word_idx;
   logic [IDX_BITS-1:0]    set_idx;
   logic [TAG_BITS-1:0]    tag;
   logic                   hit;
   logic [63:0]            stored_word;
   logic [63:0]            beat_word;
   logic                   last_beat;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^dcache_addr[2:0];

   assign word_idx    = addr_q[OFF-1:3];
   assign set_idx     = addr_q[OFF+IDX_BITS-1:OFF];
   assign tag         = addr_q[63:OFF+IDX_BITS];
   assign hit         = valid_q[set_idx] && (tag_mem[set_idx] == tag);
   assign stored_word = data_mem[{set_idx, word_idx}];
   assign last_beat   = (cnt_q == WORD_BITS'(LINE_WORDS - 1));
   // The requested word may be the final beat, which is not yet in rword_q.
   assign beat_word   = (cnt_q == word_idx) ? mem_rdata : rword_q;

   always_comb begin
      state_d     = state_q;
      wren_d      = wren_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      rword_d     = rword_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = valid_q;
      arr_we      = 1'b0;
      arr_addr    = {set_idx, word_idx};
      arr_wdata   = wdata_q;
      tag_we      = 1'b0;

      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (dcache_en) begin
               wren_d  = dcache_wren;
               addr_d  = dcache_addr[63:3];
               wdata_d = dcache_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (wren_q) begin
               arr_we      = hit;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {addr_q, 3'b000};
               mem_wdata_d = wdata_q;
               state_d     = WRITE_REQ;
            end else if (hit) begin
               rdata_d = stored_word;
               done_d  = 1'b1;
               state_d = RESP;
            end else begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {addr_q[63:OFF], {OFF{1'b0}}};
               state_d    = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               cnt_d     = '0;
               state_d   = REFILL;
            end
         end
         REFILL: begin
            if (mem_rvalid) begin
               arr_we    = 1'b1;
               arr_addr  = {set_idx, cnt_q};
               arr_wdata = mem_rdata;
               cnt_d     = cnt_q + WORD_BITS'(1);
               rword_d   = beat_word;
               if (last_beat) begin
                  valid_d[set_idx] = 1'b1;
                  tag_we           = 1'b1;
                  rdata_d          = beat_word;
                  done_d           = 1'b1;
                  state_d          = RESP;
               end
            end
         end
         WRITE_REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               rdata_d   = wdata_q;
               done_d    = 1'b1;
               state_d   = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wren_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rword_q     <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         wren_q      <= wren_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         rword_q     <= rword_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
      end
   end

   // Line storage needs no reset; the valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (arr_we) data_mem[arr_addr] <= arr_wdata;
         if (tag_we) tag_mem[set_idx]   <= tag;
      end
   end

   assign dcache_rdata = rdata_q;
   assign dcache_done  = done_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dcache_responder : directed self-checking bench for dcache_responder
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dcache_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dcache_en = 1'b0;
   logic        dcache_wren = 1'b0;
   logic [63:0] dcache_addr = '0;
   logic [63:0] dcache_wdata = '0;
   logic [63:0] dcache_rdata;
   logic        dcache_done;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;

   int          checks = 0;
   int          errors = 0;
   logic        req_ok;
   logic        seen_we;
   logic [63:0] seen_addr;
   logic [63:0] seen_wdata;

   dcache_responder #(.SETS(64), .LINE_WORDS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .dcache_en(dcache_en), .dcache_wren(dcache_wren),
      .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata), .dcache_done(dcache_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Leaves the bench at the falling edge of the LOOKUP cycle.
   task automatic issue(input logic we, input logic [63:0] a, input logic [63:0] d);
      @(negedge clk);
      dcache_en = 1'b1; dcache_wren = we; dcache_addr = a; dcache_wdata = d;
      @(negedge clk);
      dcache_en = 1'b0;
   endtask

   task automatic wait_req();
      req_ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (mem_req) begin
            req_ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
   endtask

   task automatic grant();
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
   endtask

   task automatic beats(input logic [63:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = first + 64'(i);
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (dcache_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", dcache_done); end
      checks++; if (dcache_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dcache_rdata); end
      checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_req_we: got %b want 00", {mem_req, mem_we}); end
      checks++; if ({mem_addr, mem_wdata} !== 128'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h %h want 0 0", mem_addr, mem_wdata); end
      rst_n = 1'b1;
   endtask

   task automatic test_read_miss_then_hit();
      issue(1'b0, 64'h1008, 64'h0);
      wait_req();
      checks++; if (req_ok !== 1'b1) begin errors++; $display("FAIL miss_req: got %b want 1", req_ok); end
      checks++; if (seen_addr !== 64'h1000) begin errors++; $display("FAIL miss_addr: got %h want 1000", seen_addr); end
      checks++; if (seen_we !== 1'b0) begin errors++; $display("FAIL miss_we: got %b want 0", seen_we); end
      grant();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL miss_req_drop: got %b want 0", mem_req); end
      beats(64'h10, 7);
      checks++; if (dcache_done !== 1'b0) begin errors++; $display("FAIL miss_early_done: got %b want 0", dcache_done); end
      beats(64'h17, 1);
      checks++; if (dcache_done !== 1'b1) begin errors++; $display("FAIL miss_done: got %b want 1", dcache_done); end
      checks++; if (dcache_rdata !== 64'h11) begin errors++; $display("FAIL miss_rdata: got %h want 11", dcache_rdata); end
      @(negedge clk);
      checks++; if ({dcache_done, dcache_rdata} !== {1'b0, 64'h11}) begin errors++; $display("FAIL miss_hold: got %b %h want 0 11", dcache_done, dcache_rdata); end

      issue(1'b0, 64'h1038, 64'h0);
      checks++; if ({dcache_done, mem_req} !== 2'b00) begin errors++; $display("FAIL hit_lookup: got %b want 00", {dcache_done, mem_req}); end
      @(negedge clk);
      checks++; if ({dcache_done, mem_req} !== 2'b10) begin errors++; $display("FAIL hit_done: got %b want 10", {dcache_done, mem_req}); end
      checks++; if (dcache_rdata !== 64'h17) begin errors++; $display("FAIL hit_rdata: got %h want 17", dcache_rdata); end
   endtask

   task automatic test_write_hit();
      issue(1'b1, 64'h1010, 64'hDEAD);
      wait_req();
      checks++; if (req_ok !== 1'b1) begin errors++; $display("FAIL wr_req: got %b want 1", req_ok); end
      checks++; if ({seen_we, seen_addr, seen_wdata} !== {1'b1, 64'h1010, 64'hDEAD}) begin errors++; $display("FAIL wr_fields: got %b %h %h want 1 1010 dead", seen_we, seen_addr, seen_wdata); end
      grant();
      checks++; if ({dcache_done, dcache_rdata} !== {1'b1, 64'hDEAD}) begin errors++; $display("FAIL wr_done: got %b %h want 1 dead", dcache_done, dcache_rdata); end
      @(negedge clk);
      issue(1'b0, 64'h1010, 64'h0);
      @(negedge clk);
      checks++; if ({dcache_done, mem_req, dcache_rdata} !== {2'b10, 64'hDEAD}) begin errors++; $display("FAIL wr_readback: got %b %b %h want 1 0 dead", dcache_done, mem_req, dcache_rdata); end
   endtask

   task automatic test_write_miss();
      int extra;
      issue(1'b1, 64'h9000, 64'hBEEF);
      wait_req();
      checks++; if ({req_ok, seen_we, seen_addr} !== {2'b11, 64'h9000}) begin errors++; $display("FAIL wm_req: got %b %b %h want 1 1 9000", req_ok, seen_we, seen_addr); end
      grant();
      checks++; if ({dcache_done, dcache_rdata} !== {1'b1, 64'hBEEF}) begin errors++; $display("FAIL wm_done: got %b %h want 1 beef", dcache_done, dcache_rdata); end
      extra = 0;
      repeat (4) begin @(negedge clk); if (mem_req) extra++; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL wm_single: got %0d extra req cycles want 0", extra); end
      issue(1'b0, 64'h9000, 64'h0);
      wait_req();
      checks++; if ({req_ok, seen_we, seen_addr} !== {2'b10, 64'h9000}) begin errors++; $display("FAIL wm_noalloc: got %b %b %h want 1 0 9000", req_ok, seen_we, seen_addr); end
      grant();
      beats(64'h90, 8);
      checks++; if ({dcache_done, dcache_rdata} !== {1'b1, 64'h90}) begin errors++; $display("FAIL wm_refill: got %b %h want 1 90", dcache_done, dcache_rdata); end
   endtask

   task automatic test_conflict();
      issue(1'b0, 64'h1000, 64'h0);
      wait_req(); grant(); beats(64'h10, 8);
      checks++; if ({dcache_done, dcache_rdata} !== {1'b1, 64'h10}) begin errors++; $display("FAIL cf_fill: got %b %h want 1 10", dcache_done, dcache_rdata); end
      issue(1'b0, 64'h2008, 64'h0);
      wait_req();
      checks++; if ({req_ok, seen_addr} !== {1'b1, 64'h2000}) begin errors++; $display("FAIL cf_evict_req: got %b %h want 1 2000", req_ok, seen_addr); end
      grant(); beats(64'h20, 8);
      checks++; if ({dcache_done, dcache_rdata} !== {1'b1, 64'h21}) begin errors++; $display("FAIL cf_evict_data: got %b %h want 1 21", dcache_done, dcache_rdata); end
      issue(1'b0, 64'h1000, 64'h0);
      wait_req();
      checks++; if ({req_ok, seen_addr} !== {1'b1, 64'h1000}) begin errors++; $display("FAIL cf_remiss: got %b %h want 1 1000", req_ok, seen_addr); end
      grant(); beats(64'h10, 8);
   endtask

   task automatic test_busy_ignore();
      int dones;
      int reqs;
      issue(1'b0, 64'h4008, 64'h0);
      wait_req(); grant();
      beats(64'h40, 3);
      dcache_en = 1'b1; dcache_wren = 1'b0; dcache_addr = 64'h3000;
      beats(64'h43, 1);
      dcache_en = 1'b0;
      beats(64'h44, 4);
      checks++; if ({dcache_done, dcache_rdata} !== {1'b1, 64'h41}) begin errors++; $display("FAIL busy_done: got %b %h want 1 41", dcache_done, dcache_rdata); end
      dones = 0; reqs = 0;
      repeat (6) begin @(negedge clk); if (dcache_done) dones++; if (mem_req) reqs++; end
      checks++; if ({dones, reqs} !== {32'd0, 32'd0}) begin errors++; $display("FAIL busy_extra: got done=%0d req=%0d want 0 0", dones, reqs); end
   endtask

   task automatic test_reset_mid_refill();
      issue(1'b0, 64'h5010, 64'h0);
      wait_req(); grant();
      beats(64'h50, 3);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if ({mem_req, dcache_done, dcache_rdata} !== {2'b00, 64'h0}) begin errors++; $display("FAIL rst_mid: got %b %b %h want 0 0 0", mem_req, dcache_done, dcache_rdata); end
      rst_n = 1'b1;
      issue(1'b0, 64'h5010, 64'h0);
      wait_req();
      checks++; if ({req_ok, seen_we, seen_addr} !== {2'b10, 64'h5000}) begin errors++; $display("FAIL rst_remiss: got %b %b %h want 1 0 5000", req_ok, seen_we, seen_addr); end
      grant(); beats(64'h50, 8);
      checks++; if ({dcache_done, dcache_rdata} !== {1'b1, 64'h52}) begin errors++; $display("FAIL rst_refill: got %b %h want 1 52", dcache_done, dcache_rdata); end
   endtask

   initial begin
      test_reset();
      test_read_miss_then_hit();
      test_write_hit();
      test_write_miss();
      test_conflict();
      test_busy_ignore();
      test_reset_mid_refill();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
